// File: rtl/keypad_scanner_pkg.sv
// Shared types and front-panel key codes for the matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } kp_state_t;

  localparam int unsigned KEY_HOUR_UP   = 0;
  localparam int unsigned KEY_MIN_UP    = 1;
  localparam int unsigned KEY_SET_ALARM = 2;
  localparam int unsigned KEY_SHOW_SECS = 3;

endpackage

// File: rtl/keypad_scanner_if.sv
// Key-event handshake between the keypad scanner and its consumer.
interface keypad_scanner_if #(
  parameter int unsigned KW = 4
);

  logic          key_valid;
  logic [KW-1:0] key_code;
  logic          key_ready;
  logic          key_held;
  logic          key_overrun;

  modport master (
    output key_valid,
    output key_code,
    output key_held,
    output key_overrun,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  key_held,
    input  key_overrun,
    output key_ready
  );

endinterface

// File: rtl/keypad_scanner_scan_tick.sv
// Free-running divider: one-cycle tick every DIVIDER clocks, marking the end of a column dwell.
module scan_tick
  import keypad_pkg::*;
#(
  parameter int unsigned DIVIDER = 2500
) (
  input  logic clk_in,
  input  logic reset,
  output logic tick
);

  localparam int unsigned TW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;

  logic [TW-1:0] cnt;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == TW'(DIVIDER - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == TW'(DIVIDER - 1));

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: drives one column low per dwell, debounces press/release of a single
// key and hands one event per press to the consumer over valid/ready.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned SCAN_DIVIDER   = 2500,
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_out,
  keypad_scanner_if.master key_if
);

  localparam int unsigned KW = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
  localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_SCANS + 1);

  logic [ROWS-1:0] rows_m, rows_s;
  logic            tick;

  kp_state_t       state, state_n;
  logic [CW-1:0]   col, col_n, col_adv;
  logic [RW-1:0]   cand_row, cand_row_n;
  logic [CW-1:0]   cand_col, cand_col_n;
  logic [DW-1:0]   cnt, cnt_n, cnt_inc;
  logic            press_evt;

  logic            low_seen, low_multi, one_low, all_high;
  logic [RW-1:0]   low_row;
  logic [KW-1:0]   code_n;

  logic            key_valid_q, key_overrun_q;
  logic [KW-1:0]   key_code_q;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      rows_m <= '1;
      rows_s <= '1;
    end else begin
      rows_m <= row_in;
      rows_s <= rows_m;
    end
  end

  scan_tick #(.DIVIDER(SCAN_DIVIDER)) u_scan_tick (
    .clk_in (clk_in),
    .reset  (reset),
    .tick   (tick)
  );

  // Two or more rows low at once is ambiguous (ghosting) and treated like no key.
  always_comb begin
    low_seen  = 1'b0;
    low_multi = 1'b0;
    low_row   = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      if (!rows_s[i]) begin
        low_multi = low_multi | low_seen;
        low_seen  = 1'b1;
        low_row   = RW'(i);
      end
    end
    one_low  = low_seen && !low_multi;
    all_high = &rows_s;
  end

  assign col_adv = (col == CW'(COLS - 1)) ? '0 : col + 1'b1;
  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state    <= SCAN;
      col      <= '0;
      cand_row <= '0;
      cand_col <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      col      <= col_n;
      cand_row <= cand_row_n;
      cand_col <= cand_col_n;
      cnt      <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    col_n      = col;
    cand_row_n = cand_row;
    cand_col_n = cand_col;
    cnt_n      = cnt;
    press_evt  = 1'b0;
    if (tick) begin
      unique case (state)
        SCAN: begin
          if (one_low) begin
            cand_row_n = low_row;
            cand_col_n = col;
            if (DEBOUNCE_SCANS == 1) begin
              press_evt = 1'b1;
              state_n   = HELD;
              cnt_n     = '0;
            end else begin
              cnt_n   = DW'(1);
              state_n = DEBOUNCE;
            end
          end else begin
            col_n = col_adv;
          end
        end
        DEBOUNCE: begin
          if (one_low && (low_row == cand_row)) begin
            if (cnt_inc == DW'(DEBOUNCE_SCANS)) begin
              press_evt = 1'b1;
              state_n   = HELD;
              cnt_n     = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = SCAN;
            col_n   = col_adv;
            cnt_n   = '0;
          end
        end
        HELD: begin
          if (all_high) begin
            if (cnt_inc == DW'(DEBOUNCE_SCANS)) begin
              state_n = SCAN;
              col_n   = col_adv;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cnt_n = '0;
          end
        end
        default: begin
          state_n = SCAN;
        end
      endcase
    end
  end

  always_comb begin
    col_out         = ~(COLS'(1) << col);
    key_if.key_held = (state == HELD);
  end

  // Next-cycle candidate is used so a single-scan debounce reports the key latched on this tick.
  assign code_n = KW'(cand_row_n) * KW'(COLS) + KW'(cand_col_n);

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      key_valid_q   <= 1'b0;
      key_code_q    <= '0;
      key_overrun_q <= 1'b0;
    end else begin
      key_overrun_q <= 1'b0;
      if (press_evt) begin
        if (!key_valid_q || key_if.key_ready) begin
          key_valid_q <= 1'b1;
          key_code_q  <= code_n;
        end else begin
          key_overrun_q <= 1'b1;
        end
      end else if (key_valid_q && key_if.key_ready) begin
        key_valid_q <= 1'b0;
      end
    end
  end

  assign key_if.key_valid   = key_valid_q;
  assign key_if.key_code    = key_code_q;
  assign key_if.key_overrun = key_overrun_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulated key matrix, behavioural model, per-cycle compare.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DIV  = 4;
  localparam int DEB  = 3;
  localparam int KW   = 4;

  logic            clk;
  logic            rst_n;
  logic [ROWS-1:0] row_in;
  logic [COLS-1:0] col_out;
  logic [15:0]     keys;

  keypad_scanner_if #(.KW(KW)) kif ();

  keypad_scanner #(
    .ROWS           (ROWS),
    .COLS           (COLS),
    .SCAN_DIVIDER   (DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk_in  (clk),
    .reset   (rst_n),
    .row_in  (row_in),
    .col_out (col_out),
    .key_if  (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical matrix: a closed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (keys[r*COLS+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 scanning, 1 confirming a press, 2 key held.
  logic [3:0] m_sync1, m_sync2, m_now;
  int m_tc, m_col, m_mode, m_row, m_ccol, m_streak, m_lr;
  bit m_fire;
  bit e_valid, e_overrun;
  int e_code;

  function automatic logic [3:0] sense(input int c);
    logic [3:0] r;
    r = '1;
    for (int row = 0; row < ROWS; row++)
      if (keys[row*COLS+c]) r[row] = 1'b0;
    return r;
  endfunction

  function automatic int lone_low(input logic [3:0] r);
    if ($countones(~r) != 1) return -1;
    for (int i = 0; i < ROWS; i++) if (!r[i]) return i;
    return -1;
  endfunction

  function automatic bit fire_pending();
    return (m_tc == DIV-1) && (m_mode == 1) && (m_streak == DEB-1) && (lone_low(m_sync2) == m_row);
  endfunction

  task automatic model_reset();
    m_sync1 = '1; m_sync2 = '1;
    m_tc = 0; m_col = 0; m_mode = 0; m_row = 0; m_ccol = 0; m_streak = 0;
    e_valid = 0; e_overrun = 0; e_code = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        m_now  = sense(m_col);
        m_lr   = lone_low(m_sync2);
        m_fire = 0;
        if (m_tc == DIV-1) begin
          if (m_mode == 0) begin
            if (m_lr >= 0) begin
              m_row = m_lr; m_ccol = m_col; m_streak = 1;
              if (m_streak >= DEB) begin m_fire = 1; m_mode = 2; m_streak = 0; end
              else m_mode = 1;
            end else m_col = (m_col + 1) % COLS;
          end else if (m_mode == 1) begin
            if (m_lr == m_row) begin
              m_streak++;
              if (m_streak == DEB) begin m_fire = 1; m_mode = 2; m_streak = 0; end
            end else begin
              m_mode = 0; m_col = (m_col + 1) % COLS;
            end
          end else begin
            if (m_sync2 == 4'hF) begin
              m_streak++;
              if (m_streak == DEB) begin m_mode = 0; m_streak = 0; m_col = (m_col + 1) % COLS; end
            end else m_streak = 0;
          end
        end
        e_overrun = 0;
        if (m_fire) begin
          if (!e_valid || kif.key_ready) begin e_valid = 1; e_code = m_row*COLS + m_ccol; end
          else e_overrun = 1;
        end else if (e_valid && kif.key_ready) e_valid = 0;
        m_sync2 = m_sync1;
        m_sync1 = m_now;
        m_tc = (m_tc + 1) % DIV;
      end
    end
  end

  // Per-cycle compare plus event observation.
  int   rises = 0, ovr_cnt = 0;
  int   accepted[$];
  bit   prev_valid = 0;
  logic [3:0] exp_col;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_col = ~(4'(1) << m_col);
        check("col_out", col_out, exp_col);
        check("key_valid", kif.key_valid, e_valid);
        check("key_code", kif.key_code, e_code);
        check("key_held", kif.key_held, (m_mode == 2));
        check("key_overrun", kif.key_overrun, e_overrun);
        if (kif.key_valid && !prev_valid) rises++;
        if (kif.key_overrun) ovr_cnt++;
        if (kif.key_valid && kif.key_ready) accepted.push_back(int'(kif.key_code));
        prev_valid = kif.key_valid;
      end else prev_valid = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_mode(input int target, input int budget, input string name);
    int n;
    n = 0;
    while (m_mode != target && n < budget) begin step(1); n++; end
    check(name, (m_mode == target), 1);
  endtask

  int r0, o0, a0, n;
  logic [3:0] seen;

  initial begin
    rst_n = 1'b0; keys = '0; kif.key_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_col_out", col_out, 4'b1110);
    check("rst_key_valid", kif.key_valid, 0);
    check("rst_key_code", kif.key_code, 0);
    check("rst_key_held", kif.key_held, 0);
    check("rst_key_overrun", kif.key_overrun, 0);
    rst_n = 1'b1;

    // 1: row 1 / col 2 -> code 6, ready high
    kif.key_ready = 1'b1;
    a0 = accepted.size(); r0 = rises;
    keys[6] = 1'b1;
    wait_mode(2, 200, "t1_press_timeout");
    step(3);
    check("t1_held", kif.key_held, 1);
    keys = '0;
    wait_mode(0, 200, "t1_release_timeout");
    step(2);
    check("t1_events", accepted.size() - a0, 1);
    if (accepted.size() > a0) check("t1_code", accepted[a0], 6);
    check("t1_rises", rises - r0, 1);
    check("t1_held_after", kif.key_held, 0);

    // 2: bouncing key row 0 / col 3, toggling once per dwell
    r0 = rises;
    for (int i = 0; i < 16; i++) begin keys[3] = ~keys[3]; step(DIV); end
    keys = '0;
    step(8);
    check("t2_no_event", rises - r0, 0);

    // 3: consumer stalled, codes 5 then 9
    kif.key_ready = 1'b0;
    o0 = ovr_cnt;
    keys[5] = 1'b1; wait_mode(2, 200, "t3_p1_timeout");
    keys = '0;      wait_mode(0, 200, "t3_r1_timeout");
    keys[9] = 1'b1; wait_mode(2, 200, "t3_p2_timeout");
    keys = '0;      wait_mode(0, 200, "t3_r2_timeout");
    check("t3_code_kept", kif.key_code, 5);
    check("t3_valid_kept", kif.key_valid, 1);
    check("t3_overruns", ovr_cnt - o0, 1);
    kif.key_ready = 1'b1;
    step(1);
    check("t3_valid_cleared", kif.key_valid, 0);

    // 4: ghosting, rows 0 and 2 at col 1
    r0 = rises; seen = '0;
    keys[1] = 1'b1; keys[9] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      for (int c = 0; c < COLS; c++) if (col_out == ~(4'(1) << c)) seen[c] = 1'b1;
    end
    keys = '0;
    check("t4_no_event", rises - r0, 0);
    check("t4_cols_seen", seen, 4'b1111);

    // 5: reset while confirming a press
    r0 = rises;
    keys[2] = 1'b1;
    wait_mode(1, 200, "t5_debounce_timeout");
    rst_n = 1'b0;
    #1;
    check("t5_rst_col_out", col_out, 4'b1110);
    check("t5_rst_key_valid", kif.key_valid, 0);
    keys = '0;
    step(2);
    rst_n = 1'b1;
    step(40);
    check("t5_no_event", rises - r0, 0);

    // 6: accept coinciding with a new press event
    kif.key_ready = 1'b0;
    o0 = ovr_cnt;
    keys[4] = 1'b1; wait_mode(2, 200, "t6_p1_timeout");
    keys = '0;      wait_mode(0, 200, "t6_r1_timeout");
    keys[14] = 1'b1;
    n = 0;
    while (!fire_pending() && n < 300) begin step(1); n++; end
    check("t6_fire_timeout", fire_pending(), 1);
    kif.key_ready = 1'b1;
    step(1);
    check("t6_valid_stays", kif.key_valid, 1);
    check("t6_code_updated", kif.key_code, 14);
    check("t6_no_overrun", ovr_cnt - o0, 0);
    step(1);
    check("t6_valid_cleared", kif.key_valid, 0);
    keys = '0;
    wait_mode(0, 200, "t6_r2_timeout");

    // Random presses, occasional double keys, random consumer stalls
    for (int it = 0; it < 25; it++) begin
      keys = '0;
      keys[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      n = $urandom_range(3, 50);
      for (int k = 0; k < n; k++) begin kif.key_ready = 1'($urandom_range(0, 1)); step(1); end
      keys = '0;
      n = $urandom_range(3, 40);
      for (int k = 0; k < n; k++) begin kif.key_ready = 1'($urandom_range(0, 1)); step(1); end
    end
    kif.key_ready = 1'b1;
    step(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

endmodule
